// File: rtl/m_fetch_queue.sv
// -----------------------------------------------------------------------------
// m_fetch_queue
//   Instruction-fetch front end for the 5-stage RV32I pipeline. Owns the fetch
//   PC and issues sequential word requests to an in-order, variable-latency
//   instruction memory. Returned words are buffered with their PCs in a
//   DEPTH-entry FIFO that feeds decode over a valid/ready handshake. A
//   branch-miss redirect flushes the FIFO and drops responses still in flight.
//
//   Optional feature macro: FQ_BYPASS_EN
//     defined   : a response arriving at an empty FIFO is presented to decode
//                 in the same cycle (combinational rdata -> out_ir path).
//     undefined : every word passes through the FIFO (one extra cycle).
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2); bounds count + outstanding
//   MAX_OUTST  maximum imem requests in flight (1..DEPTH)
//   RESET_PC   fetch PC after reset (word aligned)
//
// Ports
//   w_clk, w_rst_n             clock (rising edge), async active-low reset
//   w_redirect, w_redirect_pc  branch-miss redirect and new fetch PC
//   w_imem_req/gnt/addr        request channel (handshake on req & gnt)
//   w_imem_rvalid/rdata        in-order response channel
//   w_out_valid/ready          decode handshake
//   w_out_ir, w_out_pc         instruction and its PC (nop / 0 when idle)
//   w_count                    FIFO occupancy
// -----------------------------------------------------------------------------
module m_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    input  logic                       w_redirect,
    input  logic [31:0]                w_redirect_pc,
    output logic                       w_imem_req,
    input  logic                       w_imem_gnt,
    output logic [31:0]                w_imem_addr,
    input  logic                       w_imem_rvalid,
    input  logic [31:0]                w_imem_rdata,
    output logic                       w_out_valid,
    input  logic                       w_out_ready,
    output logic [31:0]                w_out_ir,
    output logic [31:0]                w_out_pc,
    output logic [$clog2(DEPTH+1)-1:0] w_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Pending-PC queue pointer advance with explicit wrap (MAX_OUTST need not be a power of 2).
    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_ir_q [DEPTH];
    logic [31:0]   fifo_ir_d [DEPTH];
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   pend_pc_q [MAX_OUTST];
    logic [31:0]   pend_pc_d [MAX_OUTST];
    logic [PW-1:0] pend_hd_q, pend_hd_d;
    logic [PW-1:0] pend_tl_q, pend_tl_d;

    logic [SW-1:0] occ_s;
    logic          req_s;
    logic          issue_s;
    logic          rv_s;
    logic          keep_s;
    logic          head_valid_s;
    logic          byp_s;
    logic          enq_s;
    logic          deq_s;

    // Handshake qualifiers: space is reserved at issue, so count+outst bounds the FIFO.
    always_comb begin
        occ_s        = SW'(count_q) + SW'(outst_q);
        req_s        = w_rst_n & ~w_redirect & (occ_s < SW'(DEPTH)) & (outst_q < OW'(MAX_OUTST));
        issue_s      = req_s & w_imem_gnt;
        // A response with nothing outstanding is a memory protocol error; ignore it.
        rv_s         = w_imem_rvalid & (outst_q != {OW{1'b0}});
        keep_s       = rv_s & (drop_q == {OW{1'b0}}) & ~w_redirect;
        head_valid_s = (count_q != {CW{1'b0}});
`ifdef FQ_BYPASS_EN
        byp_s        = keep_s & ~head_valid_s;
`else
        byp_s        = 1'b0;
`endif
        // A bypassed word taken by decode never enters the FIFO.
        enq_s        = keep_s & ~(byp_s & w_out_ready);
        deq_s        = head_valid_s & w_out_ready;
    end

    // Output drive: FIFO head when occupied, bypass word when enabled, else nop/0.
    always_comb begin
        w_imem_req  = req_s;
        w_imem_addr = pc_q;
        w_count     = count_q;
        if (head_valid_s) begin
            w_out_valid = 1'b1;
            w_out_ir    = fifo_ir_q[rd_ptr_q];
            w_out_pc    = fifo_pc_q[rd_ptr_q];
        end else if (byp_s) begin
            w_out_valid = 1'b1;
            w_out_ir    = w_imem_rdata;
            w_out_pc    = pend_pc_q[pend_hd_q];
        end else begin
            w_out_valid = 1'b0;
            w_out_ir    = NOP;
            w_out_pc    = 32'h0000_0000;
        end
    end

    // Next-state for fetch PC, outstanding/drop counters and pending-PC queue.
    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        pend_pc_d = pend_pc_q;
        pend_hd_d = pend_hd_q;
        pend_tl_d = pend_tl_q;

        if (w_redirect) begin
            pc_d = {w_redirect_pc[31:2], 2'b00};
        end else if (issue_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case ({issue_s, rv_s})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        // Everything still in flight after this edge belongs to the old path.
        if (w_redirect) begin
            drop_d = outst_q - (rv_s ? OW'(1) : OW'(0));
        end else if (rv_s && (drop_q != {OW{1'b0}})) begin
            drop_d = drop_q - OW'(1);
        end else begin
            drop_d = drop_q;
        end

        if (issue_s) begin
            pend_pc_d[pend_tl_q] = pc_q;
            pend_tl_d            = pend_inc(pend_tl_q);
        end else begin
            pend_tl_d = pend_tl_q;
        end

        // Every accepted response retires one pending PC, dropped or not.
        if (rv_s) begin
            pend_hd_d = pend_inc(pend_hd_q);
        end else begin
            pend_hd_d = pend_hd_q;
        end
    end

    // Next-state for the instruction FIFO; redirect flushes it outright.
    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        fifo_ir_d = fifo_ir_q;
        fifo_pc_d = fifo_pc_q;

        if (w_redirect) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
        end else begin
            if (enq_s) begin
                fifo_ir_d[wr_ptr_q] = w_imem_rdata;
                fifo_pc_d[wr_ptr_q] = pend_pc_q[pend_hd_q];
                wr_ptr_d            = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q      <= RESET_PC;
            outst_q   <= {OW{1'b0}};
            drop_q    <= {OW{1'b0}};
            count_q   <= {CW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            wr_ptr_q  <= {AW{1'b0}};
            pend_hd_q <= {PW{1'b0}};
            pend_tl_q <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ir_q[i] <= 32'h0000_0000;
                fifo_pc_q[i] <= 32'h0000_0000;
            end
            for (int i = 0; i < MAX_OUTST; i++) begin
                pend_pc_q[i] <= 32'h0000_0000;
            end
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pend_hd_q <= pend_hd_d;
            pend_tl_q <= pend_tl_d;
            fifo_ir_q <= fifo_ir_d;
            fifo_pc_q <= fifo_pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    m_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .OW    (OW)
    ) u_chk (
        .clk       (w_clk),
        .rst_n     (w_rst_n),
        .rvalid    (w_imem_rvalid),
        .outst     (outst_q),
        .drop      (drop_q),
        .count     (count_q)
    );

endmodule

// -----------------------------------------------------------------------------
// m_fetch_queue_chk
//   Protocol and invariant checks for m_fetch_queue (simulation only effect).
// Ports: clk, rst_n, imem rvalid, and the outst/drop/count state of the queue.
// -----------------------------------------------------------------------------
module m_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3,
    parameter int OW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rvalid,
    input logic [OW-1:0] outst,
    input logic [OW-1:0] drop,
    input logic [CW-1:0] count
);

    // The instruction memory may only respond to a granted request.
    a_rvalid_has_outst: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (outst != {OW{1'b0}}))
        else $error("imem rvalid with no outstanding request");

    // Words marked for dropping are always a subset of those in flight.
    a_drop_le_outst: assert property (@(posedge clk) disable iff (!rst_n)
        drop <= outst)
        else $error("drop counter exceeds outstanding count");

    // Reserved space guarantees occupancy stays within the FIFO.
    a_count_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH))
        else $error("FIFO occupancy exceeds DEPTH");

endmodule
